wide_add_scheduler: RTL and testbench
=====================================

Name: wide_add_scheduler

Overview:
Two-requester arbiter and sequencer that shares one external 32-bit carry-select adder. It performs WORDS×32-bit additions by driving the adder one 32-bit word per cycle, LSW first, and chaining the carry through a register. Requesters are granted round-robin. The result is returned on a valid/ready response channel tagged with the requester ID.

Parameters:
WORDS, 4, number of 32-bit words per operand (operand width W = 32*WORDS); legal range 1..16

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req0_cin  in  1  requester 0 carry-in
req1_valid / req1_ready / req1_a / req1_b / req1_cin  same as requester 0, for requester 1
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester that owns the result
resp_sum  out  W  sum
resp_cout  out  1  carry-out of the most significant word
add_a  out  32  word to the shared adder, operand A
add_b  out  32  word to the shared adder, operand B
add_cin  out  1  shared adder carry-in
add_sum  in  32  shared adder sum (combinational from add_*)
add_cout  in  1  shared adder carry-out
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, rr_ptr=0, word counter=0, carry reg=0, resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, busy=0. While rst_n=0, reqN_ready=0 and add_*=0.
- FSM states:
  - IDLE -> RUN when any reqN_valid=1.
  - RUN -> DONE after the word with index WORDS-1 is captured.
  - DONE -> IDLE on resp_valid && resp_ready.
- Arbitration (combinational, IDLE only):
  - Only one requester valid: grant it.
  - Both valid: grant rr_ptr.
  - reqN_ready = (state==IDLE) && granted==N. Ready is never asserted outside IDLE.
  - On accept: latch a, b, cin and id; rr_ptr <= ~granted_id.
- Handshake rules:
  - Requesters must hold valid and operands stable until ready.
  - reqN_valid must not depend on reqN_ready.
  - A lone requester may be granted on consecutive operations.
- RUN, word index k = 0..WORDS-1, one word per cycle:
  - add_a = a_reg[32k+31:32k], add_b = b_reg[32k+31:32k].
  - add_cin = latched cin when k=0, else carry reg.
  - At the clock edge: sum_reg[32k+31:32k] <= add_sum; carry reg <= add_cout; k++.
- Adder outputs outside RUN: add_a, add_b and add_cin are driven 0.
- DONE:
  - resp_valid=1, with resp_sum, resp_cout and resp_id stable until the handshake.
  - resp_cout equals the carry reg after the last word.
- Latency: request accepted at edge T; resp_valid=1 in the cycle after edge T+WORDS. With resp_ready tied high, the next accept happens at T+WORDS+2 at the earliest.
- Arithmetic: {resp_cout, resp_sum} = a + b + cin, modulo 2^(W+1). Exact, no saturation.
- WORDS=1: RUN lasts exactly one cycle.
- Word counter width: clog2(WORDS), minimum 1 bit.
- Simultaneous events:
  - A request arriving during RUN or DONE stalls (ready=0) and is served after return to IDLE.
  - A resp handshake and a new valid in the same cycle: the new request is granted only in the following IDLE cycle.
- Reset mid-operation: the operation is aborted and no response is produced. rr_ptr returns to 0. The requester must re-present after reset.
- No combinational path from add_sum or add_cout to any output; resp_* are registered.

Test Plan:
- WORDS=4: req0 a=all-ones (128 bits), b=0, cin=1 -> resp_sum=0, resp_cout=1, resp_id=0. resp_valid in the cycle after edge T+4. add_cin observed as 1 for words 0..3 via carry propagation.
- req1 a=0x00000001_00000002_00000003_00000004, b=0x10000000_20000000_30000000_40000000, cin=0. Required responses:
  - add_a sequence 0x4, 0x3, 0x2, 0x1 on consecutive cycles.
  - resp_sum=0x10000001_20000002_30000003_40000004, resp_cout=0.
- After reset, req0_valid and req1_valid asserted together and held for 4 operations -> grants in order 0, 1, 0, 1. Each readyN pulses for exactly one cycle; resp_id matches the grant order.
- resp_ready held low 3 cycles in DONE -> resp_valid, resp_sum and resp_id stay stable. reqN_ready=0 throughout. Accept occurs on the first resp_ready=1 cycle; the next grant follows in the IDLE cycle after.
- rst_n pulled low during RUN at k=2 -> busy=0, resp_valid=0 and add_*=0 immediately. No response is produced. A request re-presented after reset completes correctly with resp_id from rr_ptr=0 priority.
- WORDS=1 build: a=0xFFFFFFFF, b=0x00000001, cin=0 -> resp_sum=0, resp_cout=1, resp_valid in the cycle after edge T+1.

Source files
------------

// File: rtl/wide_add_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_scheduler_if
// Description : Requester, response and shared-adder signals of the wide
//               add scheduler, grouped with environment/scheduler modports.
// Revision    : 1.0
// ============================================================================
interface wide_add_scheduler_if #(
    parameter int WORDS = 4
);
    localparam int W = 32 * WORDS;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_cout;

    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_cin;
    logic [31:0]  add_sum;
    logic         add_cout;

    logic         busy;

    // Environment side: requesters, response consumer and the external adder.
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout,
        output resp_ready,
        input  add_a, add_b, add_cin,
        output add_sum, add_cout,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout,
        input  resp_ready,
        output add_a, add_b, add_cin,
        input  add_sum, add_cout,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/wide_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wide_add_scheduler
// Description : Round-robin two-requester sequencer performing WORDS x 32-bit
//               additions on one shared external 32-bit adder, LSW first.
// Revision    : 1.0
// ============================================================================
module wide_add_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_scheduler_if.slave  bus
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_rr_ptr;
    logic [CW-1:0]           r_k;
    logic                    r_carry;
    logic                    r_cin;
    logic [WORDS-1:0][31:0]  r_a;
    logic [WORDS-1:0][31:0]  r_b;
    logic [WORDS-1:0][31:0]  r_sum;
    logic                    r_resp_valid;
    logic                    r_resp_id;
    logic                    r_busy;

    logic                    w_any;
    logic                    w_grant;
    logic                    w_idle;
    logic                    w_run;
    logic [31:0]             w_a_word;
    logic [31:0]             w_b_word;

    assign w_any  = bus.req0_valid | bus.req1_valid;
    assign w_idle = (r_state == IDLE);
    assign w_run  = (r_state == RUN);

    // Contention goes to the pointer; a lone requester always wins.
    assign w_grant = (bus.req0_valid & bus.req1_valid) ? r_rr_ptr : bus.req1_valid;

    assign bus.req0_ready = rst_n & w_idle & w_any & ~w_grant;
    assign bus.req1_ready = rst_n & w_idle & w_any &  w_grant;

    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_k == CW'(i)) begin
                w_a_word = r_a[i];
                w_b_word = r_b[i];
            end
        end
    end

    assign bus.add_a   = w_run ? w_a_word : '0;
    assign bus.add_b   = w_run ? w_b_word : '0;
    assign bus.add_cin = w_run & ((r_k == '0) ? r_cin : r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= 1'b0;
            r_k          <= '0;
            r_carry      <= 1'b0;
            r_cin        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a       <= w_grant ? bus.req1_a   : bus.req0_a;
                        r_b       <= w_grant ? bus.req1_b   : bus.req0_b;
                        r_cin     <= w_grant ? bus.req1_cin : bus.req0_cin;
                        r_resp_id <= w_grant;
                        r_rr_ptr  <= ~w_grant;
                        r_k       <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_k == CW'(i)) begin
                            r_sum[i] <= bus.add_sum;
                        end
                    end
                    r_carry <= bus.add_cout;
                    if (r_k == C_LAST) begin
                        r_k          <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The carry register holds the final carry-out untouched through DONE.
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_sum   = r_sum;
    assign bus.resp_cout  = r_carry;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_add_scheduler
// Description : Self-checking bench: cycle reference model of the scheduler
//               with directed and random requester traffic, plus WORDS=1.
// Revision    : 1.0
// ============================================================================
module tb_wide_add_scheduler;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wide_add_scheduler_if #(.WORDS(WORDS)) bus ();
    wide_add_scheduler_if #(.WORDS(1))     bus1 ();

    wide_add_scheduler #(.WORDS(WORDS)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    wide_add_scheduler #(.WORDS(1))     dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // External carry-select adders modelled as plain 33-bit additions.
    assign {bus.add_cout, bus.add_sum}   = {1'b0, bus.add_a}  + {1'b0, bus.add_b}  + 33'(bus.add_cin);
    assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + 33'(bus1.add_cin);

    logic         req_valid [2];
    logic [W-1:0] req_a     [2];
    logic [W-1:0] req_b     [2];
    logic         req_cin   [2];
    logic         resp_ready;

    assign bus.req0_valid = req_valid[0];
    assign bus.req0_a     = req_a[0];
    assign bus.req0_b     = req_b[0];
    assign bus.req0_cin   = req_cin[0];
    assign bus.req1_valid = req_valid[1];
    assign bus.req1_a     = req_a[1];
    assign bus.req1_b     = req_b[1];
    assign bus.req1_cin   = req_cin[1];
    assign bus.resp_ready = resp_ready;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: operation-level state with plain arithmetic expectations.
    int           m_state;
    int           m_k;
    logic         m_ptr;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_cin;
    logic         m_id;
    logic [W:0]   lowmask;
    logic [W:0]   expc;
    logic         v0, v1, g;
    int           resp_cnt = 0;
    int           acc_cnt  = 0;
    int           grant_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_k     = 0;
            m_ptr   = 1'b0;
        end else begin
            v0 = req_valid[0];
            v1 = req_valid[1];
            g  = (v0 && v1) ? m_ptr : v1;
            chk("busy", bus.busy, m_state != 0);
            if (bus.resp_valid && resp_ready) resp_cnt++;
            if (m_state == 0) begin
                chk("ready0", bus.req0_ready, (v0 || v1) && !g);
                chk("ready1", bus.req1_ready, (v0 || v1) && g);
                chk("idle_resp_valid", bus.resp_valid, 0);
                chk("idle_adder", {bus.add_cin, bus.add_a, bus.add_b}, 0);
                if (v0 || v1) begin
                    m_a   = g ? req_a[1]   : req_a[0];
                    m_b   = g ? req_b[1]   : req_b[0];
                    m_cin = g ? req_cin[1] : req_cin[0];
                    m_id  = g;
                    m_ptr = !g;
                    grant_log.push_back(int'(g));
                    acc_cnt++;
                    m_k     = 0;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                lowmask = ~({(W+1){1'b1}} << (32 * m_k));
                expc    = (({1'b0, m_a} & lowmask) + ({1'b0, m_b} & lowmask) + (W+1)'(m_cin)) >> (32 * m_k);
                chk("add_a", bus.add_a, m_a[32*m_k +: 32]);
                chk("add_b", bus.add_b, m_b[32*m_k +: 32]);
                chk("add_cin", bus.add_cin, expc[0]);
                chk("run_ready", {bus.req0_ready, bus.req1_ready}, 0);
                chk("run_resp_valid", bus.resp_valid, 0);
                m_k++;
                if (m_k == WORDS) m_state = 2;
            end else begin
                chk("done_resp_valid", bus.resp_valid, 1);
                chk("resp_sum_cout", {bus.resp_cout, bus.resp_sum}, {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin));
                chk("resp_id", bus.resp_id, m_id);
                chk("done_ready", {bus.req0_ready, bus.req1_ready}, 0);
                chk("done_adder", {bus.add_cin, bus.add_a, bus.add_b}, 0);
                if (resp_ready) m_state = 0;
            end
        end
    end

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] r;
        if ($urandom_range(0, 3) == 0) return '1;
        for (int i = 0; i < WORDS; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int  n;
        logic rdy;
        req_a[id]     = a;
        req_b[id]     = b;
        req_cin[id]   = cin;
        req_valid[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = (id == 1) ? bus.req1_ready : bus.req0_ready;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic send_many(input int id, input int cnt);
        for (int j = 0; j < cnt; j++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(id, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic drain();
        repeat (WORDS + 4) @(posedge clk);
        #1;
    endtask

    logic stop;
    int   order_exp [4] = '{0, 1, 0, 1};

    initial begin
        rst_n      = 1'b0;
        stop       = 1'b0;
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b1;
            req_a[i]     = '1;
            req_b[i]     = '1;
            req_cin[i]   = 1'b1;
        end
        bus1.req0_valid = 1'b1;
        bus1.req0_a     = '1;
        bus1.req0_b     = '1;
        bus1.req0_cin   = 1'b1;
        bus1.req1_valid = 1'b0;
        bus1.req1_a     = '0;
        bus1.req1_b     = '0;
        bus1.req1_cin   = 1'b0;
        bus1.resp_ready = 1'b1;

        // Reset state, with requesters already valid.
        #12;
        chk("rst_ready", {bus.req0_ready, bus.req1_ready, bus1.req0_ready}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_resp", {bus.resp_valid, bus.resp_id, bus.resp_cout}, 0);
        chk("rst_resp_sum", bus.resp_sum, 0);
        chk("rst_adder", {bus.add_cin, bus.add_a, bus.add_b}, 0);
        req_valid[0]    = 1'b0;
        req_valid[1]    = 1'b0;
        bus1.req0_valid = 1'b0;
        resp_ready      = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All-ones plus carry-in: carry ripples through every word.
        send(0, '1, '0, 1'b1);
        drain();
        send(1, 128'h00000001_00000002_00000003_00000004,
                128'h10000000_20000000_30000000_40000000, 1'b0);
        drain();

        // Both requesters contending from a fresh reset.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        grant_log.delete();
        fork
            begin
                send(0, rnd_op(), rnd_op(), 1'b0);
                send(0, rnd_op(), rnd_op(), 1'b1);
            end
            begin
                send(1, rnd_op(), rnd_op(), 1'b1);
                send(1, rnd_op(), rnd_op(), 1'b0);
            end
        join
        drain();
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], order_exp[i]);

        // Consumer stalls three DONE cycles while requester 1 waits.
        resp_ready = 1'b0;
        fork
            send(0, rnd_op(), rnd_op(), 1'b1);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(1, rnd_op(), rnd_op(), 1'b0);
            end
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 50);
                if (!bus.resp_valid) chk("resp_timeout", 0, 1);
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1;
                resp_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of RUN at word 2 aborts the operation.
        send(0, rnd_op(), rnd_op(), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        chk("abort_adder", {bus.add_cin, bus.add_a, bus.add_b}, 0);
        chk("abort_ready", {bus.req0_ready, bus.req1_ready}, 0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        grant_log.delete();
        fork
            send(0, rnd_op(), rnd_op(), 1'b0);
            send(1, rnd_op(), rnd_op(), 1'b1);
        join
        drain();
        chk("post_reset_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) chk("post_reset_first", grant_log[0], 0);

        // Random traffic with a randomly stalling consumer.
        fork
            begin
                fork
                    send_many(0, 25);
                    send_many(1, 25);
                join
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        resp_ready = 1'b1;
        drain();
        chk("resp_count", resp_cnt, acc_cnt - 1);

        // Single-word build: RUN lasts exactly one cycle.
        bus1.req0_a     = '1;
        bus1.req0_b     = 32'h1;
        bus1.req0_cin   = 1'b0;
        bus1.req0_valid = 1'b1;
        @(negedge clk);
        chk("w1_ready", bus1.req0_ready, 1);
        @(posedge clk);
        #1;
        bus1.req0_valid = 1'b0;
        @(negedge clk);
        chk("w1_run", {bus1.busy, bus1.resp_valid, bus1.add_cin}, 3'b100);
        chk("w1_add_a", bus1.add_a, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("w1_resp_valid", bus1.resp_valid, 1);
        chk("w1_sum_cout", {bus1.resp_cout, bus1.resp_sum}, 33'h1_0000_0000);
        chk("w1_id", bus1.resp_id, 0);
        @(negedge clk);
        chk("w1_idle", {bus1.busy, bus1.resp_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
